// File: rtl/tdes_sequencer.sv
// tdes_sequencer: drives a single-DES core through three EDE/DED passes per job.
// Optional TDES_SINGLE_EN adds i_single, which runs one pass only using K1.
module tdes_sequencer #(
    parameter int TIMEOUT_CYC = 64,
    parameter int KEY_W       = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [64:1]    i_data,
    input  logic [KEY_W:1] i_key1,
    input  logic [KEY_W:1] i_key2,
    input  logic [KEY_W:1] i_key3,
    input  logic           i_encrypt,
`ifdef TDES_SINGLE_EN
    input  logic           i_single,
`endif
    input  logic           i_valid,
    output logic           o_ready,
    output logic [63:0]    o_data,
    output logic           o_valid,
    input  logic           i_out_ready,
    output logic           o_error,
    output logic [63:0]    core_data,
    output logic [63:0]    core_key,
    output logic           core_mode,
    output logic           core_valid,
    input  logic           core_ready,
    input  logic [63:0]    core_o_data,
    input  logic           core_o_valid
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state, state_n;
    logic [1:0]       pass;
    logic [TW-1:0]    timer;
    logic [63:0]      block;
    logic [KEY_W-1:0] k1, k2, k3, key_sel;
    logic             enc, one_pass, last_pass, timeout, accept;

    assign accept    = state == IDLE && i_valid;
    assign last_pass = pass == 2'd2 || one_pass;
    assign timeout   = state == WAIT && !core_o_valid && timer == TW'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = i_valid ? ISSUE : IDLE;
            ISSUE:   state_n = core_ready ? WAIT : ISSUE;
            WAIT:    state_n = core_o_valid ? (last_pass ? DONE : ISSUE) : (timeout ? IDLE : WAIT);
            DONE:    state_n = i_out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass  <= '0;
            timer <= '0;
            block <= '0;
            k1    <= '0;
            k2    <= '0;
            k3    <= '0;
            enc   <= 1'b0;
        end else begin
            timer <= state == WAIT ? timer + 1'b1 : '0;
            if (accept) begin
                block <= i_data;
                k1    <= i_key1;
                k2    <= i_key2;
                k3    <= i_key3;
                enc   <= i_encrypt;
                pass  <= '0;
            end
            if (state == WAIT && core_o_valid) begin
                block <= core_o_data;
                if (!last_pass)
                    pass <= pass + 2'd1;
            end
        end
    end

`ifdef TDES_SINGLE_EN
    logic single;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            single <= 1'b0;
        else if (accept)
            single <= i_single;
    end

    assign one_pass = single;
`else
    assign one_pass = 1'b0;
`endif

    // Outer passes use K1 on the encrypt side (or single mode) and K3 otherwise.
    assign key_sel = pass == 2'd1 ? k2 : ((pass == 2'd0) == (enc || one_pass)) ? k1 : k3;

    always_comb begin
        o_ready    = state == IDLE;
        o_valid    = state == DONE;
        o_data     = state == DONE ? block : '0;
        o_error    = timeout;
        core_valid = state == ISSUE && core_ready;
        core_data  = block;
        core_key   = 64'(key_sel);
        core_mode  = pass == 2'd1 ? ~enc : enc;
    end
endmodule

// File: tb/tb_tdes_sequencer.sv
// tb_tdes_sequencer: scoreboard bench with a stub DES core of fixed latency.
module tb_tdes_sequencer;
    localparam int L   = 3;
    localparam int LAT = 3 * (L + 1) + 1;
    localparam logic [63:0] KV = 64'h133457799BBCDFF1;
    localparam logic [63:0] PV = 64'h0123456789ABCDEF;
    localparam logic [63:0] CV = 64'h85E813540F0AB405;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [63:0] i_data = '0, i_key1 = '0, i_key2 = '0, i_key3 = '0;
    logic        i_encrypt = 1'b0, i_valid = 1'b0, i_out_ready = 1'b1;
    logic        o_ready, o_valid, o_error, core_mode, core_valid;
    logic [63:0] o_data, core_data, core_key, core_o_data;
    logic        core_ready = 1'b1, core_o_valid;

    logic        cov_r = 1'b0, mute = 1'b0, stray = 1'b0;
    logic [63:0] cod = '0, last_out = '0;
    int          cnt = 0, err_cnt = 0, passed = 0, total = 0;
    logic [63:0] exp_q[$];
    logic [63:0] key_q[$];
    logic        mode_q[$];

    always #5 clk = ~clk;

    tdes_sequencer #(.TIMEOUT_CYC(64), .KEY_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_key1(i_key1), .i_key2(i_key2),
        .i_key3(i_key3), .i_encrypt(i_encrypt), .i_valid(i_valid), .o_ready(o_ready),
        .o_data(o_data), .o_valid(o_valid), .i_out_ready(i_out_ready), .o_error(o_error),
        .core_data(core_data), .core_key(core_key), .core_mode(core_mode),
        .core_valid(core_valid), .core_ready(core_ready), .core_o_data(core_o_data),
        .core_o_valid(core_o_valid)
    );

    // Stub core: known DES vector under KV, otherwise an invertible toy cipher.
    function automatic logic [63:0] f_enc(input logic [63:0] d, input logic [63:0] k);
        if (d == PV && k == KV) return CV;
        return {d[58:0], d[63:59]} + k;
    endfunction

    function automatic logic [63:0] f_dec(input logic [63:0] d, input logic [63:0] k);
        logic [63:0] t;
        if (d == CV && k == KV) return PV;
        t = d - k;
        return {t[4:0], t[63:5]};
    endfunction

    function automatic logic [63:0] tdes(input logic [63:0] d, k1, k2, k3, input logic enc);
        return enc ? f_enc(f_dec(f_enc(d, k1), k2), k3) : f_dec(f_enc(f_dec(d, k3), k2), k1);
    endfunction

    assign core_o_valid = cov_r | stray;
    assign core_o_data  = cod;

    always @(posedge clk) begin
        if (core_valid) begin
            mode_q.push_back(core_mode);
            key_q.push_back(core_key);
        end
        if (core_valid && core_ready) begin
            cod   <= core_mode ? f_enc(core_data, core_key) : f_dec(core_data, core_key);
            cnt   <= L - 1;
            cov_r <= 1'b0;
        end else if (cnt > 0) begin
            cnt   <= cnt - 1;
            cov_r <= cnt == 1 && !mute;
        end else begin
            cov_r <= 1'b0;
        end
        if (o_error) err_cnt <= err_cnt + 1;
    end

    task automatic send(input logic [63:0] d, k1, k2, k3, input logic enc);
        int n = 0;
        i_data = d; i_key1 = k1; i_key2 = k2; i_key3 = k3; i_encrypt = enc; i_valid = 1'b1;
        while (!o_ready && n < 200) begin @(negedge clk); n++; end
        total++;
        if (o_ready !== 1'b1) $display("FAIL accept: o_ready=%b required 1", o_ready);
        else passed++;
        exp_q.push_back(tdes(d, k1, k2, k3, enc));
        @(negedge clk);
        i_valid = 1'b0; i_data = {$urandom, $urandom}; i_encrypt = ~enc;
        i_key1 = {$urandom, $urandom}; i_key2 = {$urandom, $urandom}; i_key3 = {$urandom, $urandom};
    endtask

    task automatic recv(output int lat);
        int n = 0;
        logic [63:0] e;
        while (!o_valid && n < 500) begin @(negedge clk); n++; end
        lat = n + 1;
        total++;
        if (o_valid !== 1'b1) $display("FAIL result_wait: o_valid=%b required 1", o_valid);
        else if (exp_q.size() == 0) $display("FAIL result_unexpected: o_data=%h required none", o_data);
        else begin
            e = exp_q.pop_front();
            last_out = o_data;
            if (o_data !== e) $display("FAIL result: o_data=%h required %h", o_data, e);
            else passed++;
        end
        @(negedge clk);
    endtask

    task automatic run_job(input logic [63:0] d, k1, k2, k3, input logic enc);
        int lat;
        logic [191:0] gk, ek;
        logic [2:0] gm, em;
        mode_q.delete(); key_q.delete();
        send(d, k1, k2, k3, enc);
        recv(lat);
        total++;
        if (lat != LAT) $display("FAIL latency: got %0d required %0d", lat, LAT);
        else passed++;
        gm = mode_q.size() == 3 ? {mode_q[0], mode_q[1], mode_q[2]} : 3'bxxx;
        em = {enc, ~enc, enc};
        total++;
        if (gm !== em) $display("FAIL modes: got %b (%0d pulses) required %b", gm, mode_q.size(), em);
        else passed++;
        gk = key_q.size() == 3 ? {key_q[0], key_q[1], key_q[2]} : 'x;
        ek = enc ? {k1, k2, k3} : {k3, k2, k1};
        total++;
        if (gk !== ek) $display("FAIL key_order: got %h required %h", gk, ek);
        else passed++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (o_ready !== 1'b1) $display("FAIL reset_ready: o_ready=%b required 1", o_ready);
        else passed++;
        total++;
        if ({o_valid, o_error, core_valid} !== 3'b000)
            $display("FAIL reset_flags: v/e/cv=%b required 000", {o_valid, o_error, core_valid});
        else passed++;
        total++;
        if ({o_data, core_data, core_key, core_mode} !== '0)
            $display("FAIL reset_data: o_data=%h core_data=%h core_key=%h core_mode=%b required 0",
                     o_data, core_data, core_key, core_mode);
        else passed++;
    endtask

    task automatic test_encrypt_vector;
        run_job(PV, KV, KV, KV, 1'b1);
        total++;
        if (last_out !== CV) $display("FAIL enc_vector: o_data=%h required %h", last_out, CV);
        else passed++;
    endtask

    task automatic test_decrypt_vector;
        run_job(CV, KV, KV, KV, 1'b0);
        total++;
        if (last_out !== PV) $display("FAIL dec_vector: o_data=%h required %h", last_out, PV);
        else passed++;
    endtask

    task automatic test_stall;
        logic [63:0] d = {$urandom, $urandom}, k1 = {$urandom, $urandom};
        int lat;
        core_ready = 1'b0;
        send(d, k1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({core_valid, core_data, core_key, core_mode} !== {1'b0, d, k1, 1'b1})
                $display("FAIL stall_%0d: cv=%b data=%h key=%h mode=%b required 0 %h %h 1",
                         i, core_valid, core_data, core_key, core_mode, d, k1);
            else passed++;
            stray = i == 4;
            @(negedge clk);
        end
        stray = 1'b0;
        core_ready = 1'b1;
        recv(lat);
    endtask

    task automatic test_done_hold;
        logic [63:0] e;
        int n = 0;
        i_out_ready = 1'b0;
        send({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        e = exp_q.pop_front();
        while (!o_valid && n < 100) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_data = {$urandom, $urandom};
            total++;
            if ({o_valid, o_ready, o_data} !== {2'b10, e})
                $display("FAIL hold_%0d: v=%b rdy=%b o_data=%h required 1 0 %h", i, o_valid, o_ready, o_data, e);
            else passed++;
            @(negedge clk);
        end
        i_out_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        total++;
        if ({o_ready, o_valid} !== 2'b10)
            $display("FAIL done_no_accept: rdy=%b v=%b required 1 0", o_ready, o_valid);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int n = 0;
        int e0 = err_cnt;
        mute = 1'b1;
        send({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        void'(exp_q.pop_back());
        while (!o_error && n < 200) begin @(negedge clk); n++; end
        total++;
        if (n != 64) $display("FAIL timeout_cycle: o_error after %0d WAIT cycles required 64", n);
        else passed++;
        @(negedge clk);
        total++;
        if ({o_ready, o_valid, o_error} !== 3'b100)
            $display("FAIL timeout_after: rdy/v/err=%b required 100", {o_ready, o_valid, o_error});
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (err_cnt != e0 + 1) $display("FAIL timeout_pulses: got %0d required 1", err_cnt - e0);
        else passed++;
        mute = 1'b0;
    endtask

    task automatic test_reset_mid;
        int n = 0, v = 0;
        mode_q.delete();
        send({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        while (mode_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({o_ready, o_valid, o_error, core_valid, core_mode, o_data, core_data, core_key} !== {1'b1, 196'd0})
            $display("FAIL reset_mid: rdy=%b v=%b err=%b cv=%b mode=%b o_data=%h data=%h key=%h required 1 0...",
                     o_ready, o_valid, o_error, core_valid, core_mode, o_data, core_data, core_key);
        else passed++;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (o_valid) v++;
            @(negedge clk);
        end
        total++;
        if (v != 0) $display("FAIL reset_abort: o_valid seen %0d cycles required 0", v);
        else passed++;
        run_job({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++)
            run_job({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, 1'(i % 2));
    endtask

    initial begin
        test_reset;
        test_encrypt_vector;
        test_decrypt_vector;
        test_stall;
        test_done_hold;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        total++;
        if (err_cnt != 1) $display("FAIL error_total: got %0d required 1", err_cnt);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
